// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR): one shift level per stage, with a
// global stall driven by output backpressure.

module barrel_shifter_pipe_stage #(
    parameter int N    = 8,
    parameter int LV   = 3,
    parameter int LVL  = 0,
    parameter bit LAST = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic          d_vld,
    input  logic [1:0]    d_op,
    input  logic [N-1:0]  d_dat,
    input  logic [LV-1:0] d_amt,
    input  logic          d_sgn,
    input  logic          d_ovs,
    output logic          q_vld,
    output logic [1:0]    q_op,
    output logic [N-1:0]  q_dat,
    output logic [LV-1:0] q_amt,
    output logic          q_sgn,
    output logic          q_ovs
);
    localparam int SH = 1 << LVL;

    logic [N-1:0] sh_dat;

    always_comb begin
        sh_dat = d_dat;
        if (d_amt[LVL]) begin
            case (d_op)
                2'b00:   sh_dat = d_dat << SH;
                2'b01:   sh_dat = d_dat >> SH;
                2'b10:   sh_dat = (d_dat >> SH) | ({N{d_sgn}} << (N - SH));
                default: sh_dat = (d_dat >> SH) | (d_dat << (N - SH));
            endcase
        end
        // Amounts >= N saturate for the linear shifts; rotate just wraps.
        if (LAST && d_ovs && d_op != 2'b11)
            sh_dat = (d_op == 2'b10) ? {N{d_sgn}} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld <= 1'b0;
            q_op  <= '0;
            q_dat <= '0;
            q_amt <= '0;
            q_sgn <= 1'b0;
            q_ovs <= 1'b0;
        end else if (adv) begin
            q_vld <= d_vld;
            q_op  <= d_op;
            q_dat <= sh_dat;
            q_amt <= d_amt;
            q_sgn <= d_sgn;
            q_ovs <= d_ovs;
        end
    end
endmodule

module barrel_shifter_pipe #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] C,
    output logic         busy
);
    localparam int LV = $clog2(N);

    logic                 adv;
    logic                 acc;
    logic [LV:1]          vld_pipe;
    logic [LV:1][1:0]     op_pipe;
    logic [LV:1][N-1:0]   dat_pipe;
    logic [LV:1][LV-1:0]  amt_pipe;
    logic [LV:1]          sgn_pipe;
    logic [LV:1]          ovs_pipe;

    assign adv       = out_ready || !out_valid;
    assign in_ready  = adv;
    assign acc       = in_valid && adv;
    assign out_valid = vld_pipe[LV];
    assign C         = dat_pipe[LV];
    assign busy      = |vld_pipe;

    for (genvar s = 0; s < LV; s++) begin : g_stage
        logic          p_vld;
        logic [1:0]    p_op;
        logic [N-1:0]  p_dat;
        logic [LV-1:0] p_amt;
        logic          p_sgn;
        logic          p_ovs;

        if (s == 0) begin : g_head
            assign p_vld = acc;
            assign p_op  = op;
            assign p_dat = A;
            assign p_amt = B[LV-1:0];
            assign p_sgn = A[N-1];
            assign p_ovs = |B[N-1:LV];
        end else begin : g_body
            assign p_vld = vld_pipe[s];
            assign p_op  = op_pipe[s];
            assign p_dat = dat_pipe[s];
            assign p_amt = amt_pipe[s];
            assign p_sgn = sgn_pipe[s];
            assign p_ovs = ovs_pipe[s];
        end

        barrel_shifter_pipe_stage #(
            .N(N), .LV(LV), .LVL(s), .LAST(s == LV - 1)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv),
            .d_vld (p_vld),
            .d_op  (p_op),
            .d_dat (p_dat),
            .d_amt (p_amt),
            .d_sgn (p_sgn),
            .d_ovs (p_ovs),
            .q_vld (vld_pipe[s+1]),
            .q_op  (op_pipe[s+1]),
            .q_dat (dat_pipe[s+1]),
            .q_amt (amt_pipe[s+1]),
            .q_sgn (sgn_pipe[s+1]),
            .q_ovs (ovs_pipe[s+1])
        );
    end

    // Side-band fields of the final stage have no consumer.
    logic unused_tail;
    assign unused_tail = ^{op_pipe[LV], amt_pipe[LV], sgn_pipe[LV], ovs_pipe[LV]};
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe at N=8 (three stages).

module tb_barrel_shifter_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [7:0] A;
    logic [7:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] C;
    logic       busy;

    int checks = 0;
    int errors = 0;

    barrel_shifter_pipe #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (C !== 8'h00)        begin errors++; $display("FAIL reset_C: got %h want 00", C); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    // Single isolated operation; entered and left #1 after a rising edge.
    task automatic test_op(input string name, input logic [1:0] o, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp);
        in_valid = 1'b1; op = o; A = a; B = b;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; A = 8'h5C; B = 8'h07; op = 2'b11;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early: out_valid=%b want 0", name, out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: out_valid=%b want 1", name, out_valid); end
        checks++; if (C !== exp)          begin errors++; $display("FAIL %s: C=%h want %h", name, C, exp); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_drain: out_valid=%b busy=%b want 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_basic();
        test_op("srl",  2'b01, 8'hB4, 8'd3, 8'h16);
        test_op("sra",  2'b10, 8'hB4, 8'd3, 8'hF6);
        test_op("sll",  2'b00, 8'hB4, 8'd2, 8'hD0);
        test_op("ror",  2'b11, 8'hB4, 8'd3, 8'h96);
        test_op("sll0", 2'b00, 8'h5A, 8'd0, 8'h5A);
        test_op("srl0", 2'b01, 8'h5A, 8'd0, 8'h5A);
        test_op("sra0", 2'b10, 8'hA5, 8'd0, 8'hA5);
        test_op("ror0", 2'b11, 8'hA5, 8'd0, 8'hA5);
    endtask

    task automatic test_oversize();
        test_op("ovs_srl", 2'b01, 8'hFF, 8'd9,   8'h00);
        test_op("ovs_sra", 2'b10, 8'h80, 8'd200, 8'hFF);
        test_op("ovs_sll", 2'b00, 8'h01, 8'd8,   8'h00);
        test_op("ovs_ror", 2'b11, 8'hB4, 8'd11,  8'h96);
        test_op("ovs_sra_pos", 2'b10, 8'h7F, 8'd16, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [1:0] vo [8];
        logic [7:0] va [8];
        logic [7:0] vb [8];
        logic [7:0] ve [8];
        vo[0] = 2'b00; va[0] = 8'h81; vb[0] = 8'd1; ve[0] = 8'h02;
        vo[1] = 2'b01; va[1] = 8'h81; vb[1] = 8'd7; ve[1] = 8'h01;
        vo[2] = 2'b10; va[2] = 8'h81; vb[2] = 8'd1; ve[2] = 8'hC0;
        vo[3] = 2'b11; va[3] = 8'h81; vb[3] = 8'd1; ve[3] = 8'hC0;
        vo[4] = 2'b11; va[4] = 8'h12; vb[4] = 8'd4; ve[4] = 8'h21;
        vo[5] = 2'b10; va[5] = 8'h7F; vb[5] = 8'd2; ve[5] = 8'h1F;
        vo[6] = 2'b00; va[6] = 8'h0F; vb[6] = 8'd4; ve[6] = 8'hF0;
        vo[7] = 2'b01; va[7] = 8'hF0; vb[7] = 8'd8; ve[7] = 8'h00;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 8) begin
                in_valid = 1'b1; op = vo[cyc]; A = va[cyc]; B = vb[cyc];
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", cyc, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (cyc >= 2) begin
                checks++; if (out_valid !== 1'b1 || C !== ve[cyc-2]) begin
                    errors++; $display("FAIL stream[%0d]: valid=%b C=%h want 1 %h", cyc - 2, out_valid, C, ve[cyc-2]);
                end
            end
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL stream_drain: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 2'b01; A = 8'hB4; B = 8'd1;
        @(posedge clk); #1;
        op = 2'b00; A = 8'h03; B = 8'd3;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_early: out_valid=%b want 0", out_valid); end
        op = 2'b11; A = 8'h01; B = 8'd1;
        @(posedge clk); #1;
        // Stall with garbage on the input; nothing should be taken.
        op = 2'b00; A = 8'hFF; B = 8'd1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || C !== 8'h5A) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%b C=%h want 1 5a", i, out_valid, C);
            end
            checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_ctrl[%0d]: in_ready=%b busy=%b want 0 1", i, in_ready, busy);
            end
            @(posedge clk); #1;
        end
        checks++; if (C !== 8'h5A) begin errors++; $display("FAIL bp_hold_end: C=%h want 5a", C); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || C !== 8'h18) begin errors++; $display("FAIL bp_r1: valid=%b C=%h want 1 18", out_valid, C); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || C !== 8'h80) begin errors++; $display("FAIL bp_r2: valid=%b C=%h want 1 80", out_valid, C); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_drain: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_midflight();
        in_valid = 1'b1; op = 2'b01; A = 8'hF0; B = 8'd1;
        @(posedge clk); #1;
        op = 2'b00; A = 8'h0F; B = 8'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || C !== 8'h00 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset: busy=%b valid=%b C=%h rdy=%b want 0 0 00 1", busy, out_valid, C, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost[%0d]: out_valid=%b want 0", i, out_valid); end
        end
        test_op("post_reset", 2'b10, 8'h90, 8'd2, 8'hE4);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; A = 8'h00; B = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_oversize();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
